// File: rtl/snd_bus_pkg.sv
// Shared definitions for the sound-chip bus arbiter: chip codes, FSM states
// and the phase counter width.
package snd_bus_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] CHIP_YM1  = 2'd0;
    localparam logic [1:0] CHIP_YM2  = 2'd1;
    localparam logic [1:0] CHIP_SAA  = 2'd2;
    localparam logic [1:0] CHIP_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Only the two YM chips can be read; the SAA is write-only.
    function automatic logic chip_readable(input logic [1:0] chip);
        return (chip == CHIP_YM1) || (chip == CHIP_YM2);
    endfunction

endpackage

// File: rtl/snd_bus_rr_sel.sv
// Two-way grant select between host (H) and GS/sequencer (G) requests.
// SNDBUS_RR_EN selects round-robin; otherwise H has fixed priority.
module snd_bus_rr_sel (
    input  logic h_req,
    input  logic g_req,
    input  logic last_grant_g,
    output logic grant_g
);

`ifdef SNDBUS_RR_EN
    // On a tie the requester that did not win last time is served.
    assign grant_g = g_req & (~h_req | ~last_grant_g);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_g;
    assign grant_g           = g_req & ~h_req;
`endif

endmodule

// File: rtl/snd_bus_arbiter.sv
// Sound-chip bus arbiter: sequences one H or G access at a time as
// setup/strobe/hold phases; arbitration mode chosen by SNDBUS_RR_EN.
module snd_bus_arbiter
    import snd_bus_pkg::*;
#(
    parameter int T_SU = 2,
    parameter int T_ST = 4,
    parameter int T_HD = 2
) (
    input  logic       clk32,
    input  logic       rst_n,
    input  logic       h_req,
    input  logic       h_we,
    input  logic [1:0] h_chip,
    input  logic       h_a0,
    input  logic [7:0] h_wdata,
    output logic       h_ack,
    input  logic       g_req,
    input  logic       g_we,
    input  logic [1:0] g_chip,
    input  logic       g_a0,
    input  logic [7:0] g_wdata,
    output logic       g_ack,
    output logic [7:0] rdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       aa0,
    output logic       n_ard,
    output logic       n_awr,
    output logic       n_ym1_cs,
    output logic       n_ym2_cs,
    output logic       n_saa_cs,
    output logic       busy
);

    localparam logic [CNT_W-1:0] SU_LOAD = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] ST_LOAD = CNT_W'(T_ST - 1);
    localparam logic [CNT_W-1:0] HD_LOAD = CNT_W'(T_HD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_g_q, last_g_d;
    logic             gnt_g_q, gnt_g_d;
    logic             we_q, we_d;
    logic [1:0]       chip_q, chip_d;
    logic             a0_q, a0_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rbuf_q, rbuf_d;
    logic             sel_g;

    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;
    logic       aa0_q, aa0_d;
    logic       n_ard_q, n_ard_d;
    logic       n_awr_q, n_awr_d;
    logic       n_ym1_cs_q, n_ym1_cs_d;
    logic       n_ym2_cs_q, n_ym2_cs_d;
    logic       n_saa_cs_q, n_saa_cs_d;
    logic       h_ack_q, h_ack_d;
    logic       g_ack_q, g_ack_d;
    logic [7:0] rdata_q, rdata_d;
    logic       on_bus, in_strobe, last_hold;

    snd_bus_rr_sel u_rr_sel (
        .h_req        (h_req),
        .g_req        (g_req),
        .last_grant_g (last_g_q),
        .grant_g      (sel_g)
    );

    always_ff @(posedge clk32) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_g_q <= 1'b1;
            gnt_g_q  <= 1'b0;
            we_q     <= 1'b0;
            chip_q   <= CHIP_NONE;
            a0_q     <= 1'b0;
            wdata_q  <= 8'h00;
            rbuf_q   <= 8'hFF;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_g_q <= last_g_d;
            gnt_g_q  <= gnt_g_d;
            we_q     <= we_d;
            chip_q   <= chip_d;
            a0_q     <= a0_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
        end
    end

    // Requester fields are captured only at grant; read data is captured
    // on the final strobe cycle while n_ard is still low on the pins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_g_d = last_g_q;
        gnt_g_d  = gnt_g_q;
        we_d     = we_q;
        chip_d   = chip_q;
        a0_d     = a0_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (h_req || g_req) begin
                    state_d  = ST_SETUP;
                    cnt_d    = SU_LOAD;
                    gnt_g_d  = sel_g;
                    last_g_d = sel_g;
                    we_d     = sel_g ? g_we    : h_we;
                    chip_d   = sel_g ? g_chip  : h_chip;
                    a0_d     = sel_g ? g_a0    : h_a0;
                    wdata_d  = sel_g ? g_wdata : h_wdata;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = ST_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HD_LOAD;
                    rbuf_d  = chip_readable(chip_q) ? ad_in : 8'hFF;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the current phase and registered, so the
    // bus trails the FSM by one cycle and never sees requester inputs directly.
    always_comb begin
        on_bus     = (state_q != ST_IDLE);
        in_strobe  = (state_q == ST_STROBE);
        last_hold  = (state_q == ST_HOLD) && (cnt_q == '0);
        ad_oe_d    = on_bus && we_q;
        ad_out_d   = (on_bus && we_q) ? wdata_q : 8'h00;
        aa0_d      = on_bus && a0_q;
        n_ym1_cs_d = !(on_bus && (chip_q == CHIP_YM1));
        n_ym2_cs_d = !(on_bus && (chip_q == CHIP_YM2));
        n_saa_cs_d = !(on_bus && (chip_q == CHIP_SAA));
        n_awr_d    = !(in_strobe && we_q);
        n_ard_d    = !(in_strobe && !we_q && chip_readable(chip_q));
        h_ack_d    = last_hold && !gnt_g_q;
        g_ack_d    = last_hold && gnt_g_q;
        rdata_d    = (last_hold && !we_q) ? rbuf_q : rdata_q;
    end

    always_ff @(posedge clk32) begin
        if (!rst_n) begin
            ad_out_q   <= 8'h00;
            ad_oe_q    <= 1'b0;
            aa0_q      <= 1'b0;
            n_ard_q    <= 1'b1;
            n_awr_q    <= 1'b1;
            n_ym1_cs_q <= 1'b1;
            n_ym2_cs_q <= 1'b1;
            n_saa_cs_q <= 1'b1;
            h_ack_q    <= 1'b0;
            g_ack_q    <= 1'b0;
            rdata_q    <= 8'hFF;
        end else begin
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            aa0_q      <= aa0_d;
            n_ard_q    <= n_ard_d;
            n_awr_q    <= n_awr_d;
            n_ym1_cs_q <= n_ym1_cs_d;
            n_ym2_cs_q <= n_ym2_cs_d;
            n_saa_cs_q <= n_saa_cs_d;
            h_ack_q    <= h_ack_d;
            g_ack_q    <= g_ack_d;
            rdata_q    <= rdata_d;
        end
    end

    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign aa0      = aa0_q;
    assign n_ard    = n_ard_q;
    assign n_awr    = n_awr_q;
    assign n_ym1_cs = n_ym1_cs_q;
    assign n_ym2_cs = n_ym2_cs_q;
    assign n_saa_cs = n_saa_cs_q;
    assign h_ack    = h_ack_q;
    assign g_ack    = g_ack_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_snd_bus_arbiter.sv
// Self-checking bench for snd_bus_arbiter: default-timing instance plus a
// T_SU=T_ST=T_HD=1 instance, checked against a cycle-indexed timing model.
module tb_snd_bus_arbiter;

    logic       clk32 = 1'b0;
    logic       rst_n;
    logic       h_req, h_we, h_a0, g_req, g_we, g_a0;
    logic [1:0] h_chip, g_chip;
    logic [7:0] h_wdata, g_wdata, ad_in;
    logic       h_ack, g_ack, ad_oe, aa0, n_ard, n_awr, n_ym1_cs, n_ym2_cs, n_saa_cs, busy;
    logic [7:0] rdata, ad_out;

    logic       f_h_req, f_h_we, f_h_a0;
    logic [1:0] f_h_chip;
    logic [7:0] f_h_wdata;
    logic       f_h_ack, f_g_ack, f_ad_oe, f_aa0, f_n_ard, f_n_awr;
    logic       f_n_ym1_cs, f_n_ym2_cs, f_n_saa_cs, f_busy;
    logic [7:0] f_rdata, f_ad_out;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         model_last_g = 1'b1;
    logic [7:0] model_rdata  = 8'hFF;

    always #5 clk32 = ~clk32;

    snd_bus_arbiter dut (
        .clk32(clk32), .rst_n(rst_n),
        .h_req(h_req), .h_we(h_we), .h_chip(h_chip), .h_a0(h_a0), .h_wdata(h_wdata), .h_ack(h_ack),
        .g_req(g_req), .g_we(g_we), .g_chip(g_chip), .g_a0(g_a0), .g_wdata(g_wdata), .g_ack(g_ack),
        .rdata(rdata), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .aa0(aa0),
        .n_ard(n_ard), .n_awr(n_awr), .n_ym1_cs(n_ym1_cs), .n_ym2_cs(n_ym2_cs),
        .n_saa_cs(n_saa_cs), .busy(busy)
    );

    snd_bus_arbiter #(.T_SU(1), .T_ST(1), .T_HD(1)) dut_fast (
        .clk32(clk32), .rst_n(rst_n),
        .h_req(f_h_req), .h_we(f_h_we), .h_chip(f_h_chip), .h_a0(f_h_a0), .h_wdata(f_h_wdata),
        .h_ack(f_h_ack),
        .g_req(1'b0), .g_we(1'b0), .g_chip(2'd3), .g_a0(1'b0), .g_wdata(8'h00), .g_ack(f_g_ack),
        .rdata(f_rdata), .ad_in(ad_in), .ad_out(f_ad_out), .ad_oe(f_ad_oe), .aa0(f_aa0),
        .n_ard(f_n_ard), .n_awr(f_n_awr), .n_ym1_cs(f_n_ym1_cs), .n_ym2_cs(f_n_ym2_cs),
        .n_saa_cs(f_n_saa_cs), .busy(f_busy)
    );

    // Pin snapshot; ad_out only matters while the bus is driven.
    function automatic logic [17:0] pins_main();
        return {n_ym1_cs, n_ym2_cs, n_saa_cs, n_ard, n_awr, ad_oe, aa0,
                (ad_oe ? ad_out : 8'h00), h_ack, g_ack, busy};
    endfunction

    function automatic logic [17:0] pins_fast();
        return {f_n_ym1_cs, f_n_ym2_cs, f_n_saa_cs, f_n_ard, f_n_awr, f_ad_oe, f_aa0,
                (f_ad_oe ? f_ad_out : 8'h00), f_h_ack, f_g_ack, f_busy};
    endfunction

    // Expected pins k cycles after the grant edge (k=1 is the cycle right after it):
    // the bus is active for su+st+hd cycles from k=2, strobe starts after setup,
    // ack lands at k = 1+su+st+hd, busy covers the non-IDLE states k=1..su+st+hd.
    function automatic logic [17:0] model_pins(input int k, input int su, input int st, input int hd,
                                               input bit is_g, input bit we, input logic [1:0] chip,
                                               input bit a0, input logic [7:0] wd);
        int span;
        bit act, stb, ack, readable;
        span     = su + st + hd;
        act      = (k >= 2) && (k <= span + 1);
        stb      = (k >= 2 + su) && (k < 2 + su + st);
        ack      = (k == span + 1);
        readable = (chip == 2'd0) || (chip == 2'd1);
        return {!(act && chip == 2'd0), !(act && chip == 2'd1), !(act && chip == 2'd2),
                !(stb && !we && readable), !(stb && we), act && we, act && a0,
                (act && we) ? wd : 8'h00, ack && !is_g, ack && is_g, (k >= 1) && (k <= span)};
    endfunction

    // Tie-break rule: round-robin serves whoever was not granted last; fixed mode favours H.
    function automatic bit model_pick_g(input bit h, input bit g);
`ifdef SNDBUS_RR_EN
        if (h && g) return !model_last_g;
`else
        if (h && g) return 1'b0;
`endif
        return g;
    endfunction

    task automatic set_req(input bit is_g, input bit req, input bit we, input logic [1:0] chip,
                           input bit a0, input logic [7:0] wd);
        if (is_g) begin
            g_req = req; g_we = we; g_chip = chip; g_a0 = a0; g_wdata = wd;
        end else begin
            h_req = req; h_we = we; h_chip = chip; h_a0 = a0; h_wdata = wd;
        end
    endtask

    task automatic test_reset();
        logic [17:0] idle_pins;
        idle_pins = model_pins(0, 2, 4, 2, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        f_h_req = 1'b0; f_h_we = 1'b0; f_h_chip = 2'd0; f_h_a0 = 1'b0; f_h_wdata = 8'h00;
        ad_in = 8'h00;
        repeat (2) @(negedge clk32);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk32);
            n_checks++;
            if (pins_main() !== idle_pins) begin
                n_fail++; $display("[TB] FAIL reset_pins got %h want %h", pins_main(), idle_pins);
            end
            n_checks++;
            if (rdata !== 8'hFF) begin
                n_fail++; $display("[TB] FAIL reset_rdata got %h want ff", rdata);
            end
            n_checks++;
            if (pins_fast() !== idle_pins) begin
                n_fail++; $display("[TB] FAIL reset_fast_pins got %h want %h", pins_fast(), idle_pins);
            end
        end
        rst_n        = 1'b1;
        model_last_g = 1'b1;
        model_rdata  = 8'hFF;
        @(negedge clk32);
    endtask

    task automatic test_host_write();
        logic [17:0] exp;
        set_req(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 8'hA5);
        model_last_g = model_pick_g(1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk32);
            exp = model_pins(k, 2, 4, 2, 1'b0, 1'b1, 2'd0, 1'b1, 8'hA5);
            n_checks++;
            if (pins_main() !== exp) begin
                n_fail++; $display("[TB] FAIL host_write k=%0d got %h want %h", k, pins_main(), exp);
            end
            if (k == 9) begin
                h_req = 1'b0;
                n_checks++;
                if (rdata !== model_rdata) begin
                    n_fail++; $display("[TB] FAIL host_write_rdata got %h want %h", rdata, model_rdata);
                end
            end
        end
    endtask

    task automatic test_g_read();
        logic [17:0] exp;
        ad_in = 8'h3C;
        set_req(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00);
        model_last_g = model_pick_g(1'b0, 1'b1);
        model_rdata  = 8'h3C;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk32);
            exp = model_pins(k, 2, 4, 2, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00);
            n_checks++;
            if (pins_main() !== exp) begin
                n_fail++; $display("[TB] FAIL g_read k=%0d got %h want %h", k, pins_main(), exp);
            end
            if (k >= 9) begin
                g_req = 1'b0;
                n_checks++;
                if (rdata !== model_rdata) begin
                    n_fail++; $display("[TB] FAIL g_read_rdata k=%0d got %h want %h", k, rdata, model_rdata);
                end
            end
        end
    endtask

    task automatic test_saa_none();
        logic [17:0] exp;
        bit          we_tab [2] = '{1'b0, 1'b1};
        logic [1:0]  chip_tab [2] = '{2'd2, 2'd3};
        ad_in = 8'h5A;
        for (int t = 0; t < 2; t++) begin
            set_req(1'b0, 1'b1, we_tab[t], chip_tab[t], 1'b0, 8'hC3);
            model_last_g = model_pick_g(1'b1, 1'b0);
            if (!we_tab[t]) model_rdata = 8'hFF;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk32);
                exp = model_pins(k, 2, 4, 2, 1'b0, we_tab[t], chip_tab[t], 1'b0, 8'hC3);
                n_checks++;
                if (pins_main() !== exp) begin
                    n_fail++; $display("[TB] FAIL saa_none t=%0d k=%0d got %h want %h", t, k, pins_main(), exp);
                end
                if (k == 9) begin
                    h_req = 1'b0;
                    n_checks++;
                    if (rdata !== model_rdata) begin
                        n_fail++; $display("[TB] FAIL saa_none_rdata t=%0d got %h want %h", t, rdata, model_rdata);
                    end
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [17:0] exp;
        bit          who;
        set_req(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h11);
        set_req(1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'h22);
        for (int n = 0; n < 4; n++) begin
            who          = model_pick_g(1'b1, 1'b1);
            model_last_g = who;
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk32);
                exp = who ? model_pins(k, 2, 4, 2, 1'b1, 1'b1, 2'd1, 1'b1, 8'h22)
                          : model_pins(k, 2, 4, 2, 1'b0, 1'b1, 2'd0, 1'b0, 8'h11);
                n_checks++;
                if (pins_main() !== exp) begin
                    n_fail++; $display("[TB] FAIL round_robin n=%0d k=%0d got %h want %h", n, k, pins_main(), exp);
                end
                if (n == 3 && k == 9) begin
                    h_req = 1'b0;
                    g_req = 1'b0;
                end
            end
        end
        @(negedge clk32);
    endtask

    task automatic test_reset_mid();
        logic [17:0] exp;
        set_req(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h6E);
        for (int k = 1; k <= 4; k++) @(negedge clk32);
        rst_n = 1'b0;
        @(negedge clk32);
        exp = model_pins(0, 2, 4, 2, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        n_checks++;
        if (pins_main() !== exp) begin
            n_fail++; $display("[TB] FAIL reset_mid_pins got %h want %h", pins_main(), exp);
        end
        n_checks++;
        if (rdata !== 8'hFF) begin
            n_fail++; $display("[TB] FAIL reset_mid_rdata got %h want ff", rdata);
        end
        rst_n        = 1'b1;
        model_last_g = 1'b1;
        model_rdata  = 8'hFF;
        model_last_g = model_pick_g(1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk32);
            exp = model_pins(k, 2, 4, 2, 1'b0, 1'b1, 2'd1, 1'b1, 8'h6E);
            n_checks++;
            if (pins_main() !== exp) begin
                n_fail++; $display("[TB] FAIL reset_mid_regrant k=%0d got %h want %h", k, pins_main(), exp);
            end
            if (k == 9) h_req = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [17:0] exp;
        bit          who, we, a0;
        logic [1:0]  chip;
        logic [7:0]  wd;
        for (int t = 0; t < 16; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk32);
                exp = model_pins(0, 2, 4, 2, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
                n_checks++;
                if (pins_main() !== exp) begin
                    n_fail++; $display("[TB] FAIL random_gap t=%0d got %h want %h", t, pins_main(), exp);
                end
            end
            who   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            a0    = 1'($urandom_range(0, 1));
            chip  = 2'($urandom_range(0, 3));
            wd    = 8'($urandom_range(0, 255));
            ad_in = 8'($urandom_range(0, 255));
            set_req(who, 1'b1, we, chip, a0, wd);
            model_last_g = model_pick_g(!who, who);
            if (!we) model_rdata = ((chip == 2'd0) || (chip == 2'd1)) ? ad_in : 8'hFF;
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk32);
                exp = model_pins(k, 2, 4, 2, who, we, chip, a0, wd);
                n_checks++;
                if (pins_main() !== exp) begin
                    n_fail++; $display("[TB] FAIL random t=%0d k=%0d got %h want %h", t, k, pins_main(), exp);
                end
                if (k == 3) begin
                    set_req(who, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                end
                if (k == 9) begin
                    set_req(who, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
                    n_checks++;
                    if (rdata !== model_rdata) begin
                        n_fail++; $display("[TB] FAIL random_rdata t=%0d got %h want %h", t, rdata, model_rdata);
                    end
                end
            end
        end
        @(negedge clk32);
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp;
        logic [7:0]  wd;
        bit          a0;
        for (int t = 0; t < 3; t++) begin
            wd = 8'($urandom_range(0, 255));
            a0 = 1'($urandom_range(0, 1));
            f_h_req = 1'b1; f_h_we = 1'b1; f_h_chip = 2'd2; f_h_a0 = a0; f_h_wdata = wd;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk32);
                exp = model_pins(k, 1, 1, 1, 1'b0, 1'b1, 2'd2, a0, wd);
                n_checks++;
                if (pins_fast() !== exp) begin
                    n_fail++; $display("[TB] FAIL back_to_back t=%0d k=%0d got %h want %h", t, k, pins_fast(), exp);
                end
                if (k == 4) f_h_req = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_g_read();
        test_saa_none();
        test_round_robin();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/snd_bus_arbiter.md
Name: snd_bus_arbiter

Overview:
Arbitrates the shared external sound-chip bus (ad, aa0, n_ard, n_awr, chip selects for YM1/YM2/SAA) between two requesters.
- Requester H: host Z80 port-access front end.
- Requester G: GS-side or internal sequencer.
Runs on clk32 and sequences each access as setup/strobe/hold phases with programmable cycle counts. This replaces direct combinational drive of the chip bus from CPU strobes.

Parameters:
T_SU, 2, setup cycles (address/CS/data valid before strobe); legal 1..15
T_ST, 4, strobe cycles (n_ard/n_awr low); legal 1..15
T_HD, 2, hold cycles (CS/address/data held after strobe); legal 1..15

Ports:
clk32  in  1  system clock, 32 MHz
rst_n  in  1  synchronous active-low reset
h_req  in  1  host request, level; held until h_ack
h_we  in  1  host 1=write, 0=read
h_chip  in  2  host target: 0=YM1, 1=YM2, 2=SAA, 3=none
h_a0  in  1  host chip A0
h_wdata  in  8  host write data
h_ack  out  1  host completion pulse, 1 cycle
g_req, g_we, g_chip, g_a0, g_wdata, g_ack: same as h_* for requester G
rdata  out  8  read data, valid in the h_ack/g_ack cycle and held until the next ack
ad_in  in  8  chip bus data in
ad_out  out  8  chip bus data out
ad_oe  out  1  chip bus output enable
aa0  out  1  chip A0
n_ard  out  1  read strobe, active low
n_awr  out  1  write strobe, active low
n_ym1_cs  out  1  YM1 select, active low
n_ym2_cs  out  1  YM2 select, active low
n_saa_cs  out  1  SAA select, active low
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-low on clk32. On the first edge with rst_n=0, the following take effect, including mid-transaction (the transaction is abandoned and no ack is issued):
  - state=IDLE
  - all n_* outputs=1, ad_oe=0, ad_out=0, aa0=0
  - h_ack=g_ack=0, rdata=8'hFF, busy=0
  - last_grant=G
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. A phase counter is loaded with (T-1) on entry to each phase; the state advances when the counter reaches 0.
- IDLE:
  - If any request is pending, grant one, latch we/chip/a0/wdata into internal registers, and go to SETUP.
  - Requester fields are sampled only at grant; later changes are ignored.
- Arbitration when both requests are high: grant the requester that is not last_grant (round-robin). With a single request, grant it. last_grant updates at grant.
- SETUP, STROBE and HOLD:
  - aa0 = latched a0.
  - The CS of the latched chip is low for all three phases; chip=3 asserts no CS.
  - For writes: ad_oe=1 and ad_out=wdata for all three phases.
- STROBE:
  - For writes, n_awr=0.
  - For reads, n_ard=0, except when chip is SAA or 3: SAA is write-only, so no n_ard, and rdata is forced to 8'hFF.
- Read capture: rdata <= ad_in on the last STROBE cycle.
- HOLD: in the last cycle, pulse the granted requester's ack for 1 cycle.
- After HOLD, the FSM always spends at least 1 cycle in IDLE as a bus turnaround gap.
- Latency from req rising in IDLE to ack: 1+T_SU+T_ST+T_HD cycles (defaults: 9).
- After an ack, the requester must drop req in the same cycle. If req is still high on the next IDLE cycle, it counts as a new request.
- A request dropped before its ack is a protocol violation. The transaction still completes and acks.
- Outputs are registered. No combinational path from h_*/g_* to bus pins.

Optional Feature:
SNDBUS_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, H always wins simultaneous requests. last_grant is still maintained but has no effect. G can be starved by continuous H traffic; this is acceptable in that configuration.

Decomposition:
- Package snd_bus_pkg:
  - chip codes CHIP_YM1=0, CHIP_YM2=1, CHIP_SAA=2, CHIP_NONE=3
  - FSM state encoding (IDLE, SETUP, STROBE, HOLD)
  - phase counter width 4
- Sub-module snd_bus_rr_sel: 2-way grant logic. Inputs h_req, g_req, last_grant; output grant select. Contains the SNDBUS_RR_EN switch.

Test Plan:
- Host write, h_chip=0, h_a0=1, h_wdata=8'hA5, defaults -> n_ym1_cs low 8 cycles, n_awr low cycles 4..7 after grant, ad_out=8'hA5 with ad_oe=1 throughout, aa0=1, h_ack at cycle 9.
- G read, g_chip=1, ad_in=8'h3C -> n_ym2_cs and n_ard asserted (4 cycles), rdata=8'h3C with g_ack; n_awr stays high and ad_oe=0 throughout.
- SAA read (chip=2, we=0) -> n_saa_cs low, no n_ard pulse, rdata=8'hFF at ack; chip=3 write -> no CS asserted, ack still after 9 cycles.
- Continuous h_req and g_req -> grants alternate H,G,H,G with 1 idle cycle between. Without SNDBUS_RR_EN -> only H is granted.
- rst_n=0 during STROBE -> next edge: all strobes/CS high, ad_oe=0, no ack. After release, pending req is granted fresh and completes in 9 cycles.
- T_SU=1, T_ST=1, T_HD=1 -> ack 4 cycles after req; back-to-back host writes spaced by 5 cycles.
